// File: rtl/width_allocator.sv
// Placement controller in front of the per-ID occupied-width RAM: reads three
// candidates, picks the first with room, accumulates into it and reports.
module width_allocator #(
  parameter int CAPACITY = 127,
  parameter int MIN_W    = 4,
  parameter int MAX_W    = 16,
  parameter int LAST_ID  = 12,
  parameter int FAIL_ID  = 13
) (
  input  logic       enclk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_width,
  input  logic [3:0] req_id1,
  input  logic [3:0] req_id2,
  input  logic [3:0] req_id3,
  output logic [3:0] rd_id1,
  output logic [3:0] rd_id2,
  output logic [3:0] rd_id3,
  input  logic [6:0] rd_width1,
  input  logic [6:0] rd_width2,
  input  logic [6:0] rd_width3,
  output logic       ram_we,
  output logic [3:0] ram_write_id,
  output logic [4:0] ram_write_width,
  output logic       resp_valid,
  output logic       resp_ok,
  output logic [3:0] resp_id,
  output logic [1:0] resp_slot,
  output logic [7:0] alloc_count,
  output logic [7:0] reject_count
);

  localparam logic [7:0] CAP8    = CAPACITY[7:0];
  localparam logic [4:0] MIN_W5  = MIN_W[4:0];
  localparam logic [4:0] MAX_W5  = MAX_W[4:0];
  localparam logic [3:0] LAST4   = LAST_ID[3:0];
  localparam logic [3:0] FAIL4   = FAIL_ID[3:0];

  typedef enum logic [2:0] {IDLE, READ, DECIDE, WSETUP, WRITE, RESP} state_t;

  state_t          state, nxt;
  logic [4:0]      cap_width;
  logic [2:0][3:0] cap_id;
  logic [2:0][6:0] rdw;
  logic [2:0]      fits;
  logic [1:0]      sel_slot, pick_slot, fin_slot;
  logic [3:0]      pick_id, fin_id;
  logic            width_ok;

  assign rdw      = {rd_width3, rd_width2, rd_width1};
  assign width_ok = (req_width >= MIN_W5) && (req_width <= MAX_W5);

  // 8-bit sum so a full RAM entry plus a max-width item cannot wrap
  for (genvar k = 0; k < 3; k++) begin : g_fit
    assign fits[k] = (cap_id[k] <= LAST4) &&
                     (({1'b0, rdw[k]} + {3'b000, cap_width}) <= CAP8);
  end

  always_comb begin
    pick_slot = 2'd0;
    pick_id   = FAIL4;
    for (int k = 2; k >= 0; k--) begin
      if (fits[k]) begin
        pick_slot = 2'(k + 1);
        pick_id   = cap_id[k];
      end
    end
  end

  // Outcome that goes into the response when RESP is entered
  always_comb begin
    fin_slot = sel_slot;
    fin_id   = ram_write_id;
    if (state == IDLE) begin
      fin_slot = 2'd0;
      fin_id   = FAIL4;
    end else if (state == DECIDE) begin
      fin_slot = pick_slot;
      fin_id   = pick_id;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = width_ok ? READ : RESP;
      READ:    nxt = DECIDE;
      DECIDE:  nxt = (pick_slot != 2'd0) ? WSETUP : RESP;
      WSETUP:  nxt = WRITE;
      WRITE:   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge enclk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      cap_width       <= '0;
      cap_id          <= '0;
      sel_slot        <= '0;
      rd_id1          <= FAIL4;
      rd_id2          <= FAIL4;
      rd_id3          <= FAIL4;
      ram_we          <= 1'b0;
      ram_write_id    <= '0;
      ram_write_width <= '0;
      resp_valid      <= 1'b0;
      resp_ok         <= 1'b0;
      resp_id         <= FAIL4;
      resp_slot       <= '0;
      alloc_count     <= '0;
      reject_count    <= '0;
    end else begin
      state      <= nxt;
      req_ready  <= (nxt == IDLE);
      ram_we     <= (nxt == WRITE);
      resp_valid <= (nxt == RESP);
      if (state == IDLE && req_valid) begin
        cap_width <= req_width;
        cap_id    <= {req_id3, req_id2, req_id1};
        sel_slot  <= 2'd0;
      end
      if (nxt == READ) begin
        rd_id1 <= req_id1;
        rd_id2 <= req_id2;
        rd_id3 <= req_id3;
      end else if (nxt == IDLE) begin
        rd_id1 <= FAIL4;
        rd_id2 <= FAIL4;
        rd_id3 <= FAIL4;
      end
      if (state == DECIDE) begin
        sel_slot <= pick_slot;
        if (pick_slot != 2'd0) begin
          ram_write_id    <= pick_id;
          ram_write_width <= cap_width;
        end
      end
      if (nxt == RESP) begin
        resp_ok   <= (fin_slot != 2'd0);
        resp_id   <= fin_id;
        resp_slot <= fin_slot;
        if (fin_slot != 2'd0) begin
          if (alloc_count != 8'hFF) alloc_count <= alloc_count + 8'd1;
        end else begin
          if (reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
        end
      end
    end
  end

endmodule
